// File: rtl/demux_serializer_pkg.sv
// Shared types and sizing for the demux_serializer block.
package demux_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned CHANNELS = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned HOLD_W   = 8;

endpackage

// File: rtl/demux_serializer_hold_timer.sv
// Per-channel dwell counter: synchronous clear/enable, terminal count at HOLD_CYCLES-1.
module hold_timer
    import demux_serializer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/demux_serializer.sv
// Serialises a captured 8-bit word onto the demux data line, stepping the selects per channel.
module demux_serializer
    import demux_serializer_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       a,
    output logic       s0,
    output logic       s1,
    output logic       s2
);

    state_e            state_q, state_d;
    logic [7:0]        word_q, word_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              timer_clear;
    logic              timer_en;
    logic              tc;

    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              a_q, a_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .enable(timer_en),
        .tc    (tc)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        ch_d        = ch_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    word_d      = data_in;
                    ch_d        = '0;
                    timer_clear = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                timer_en = 1'b1;
                if (tc) begin
                    timer_clear = 1'b1;
                    if (ch_q == SEL_W'(CHANNELS - 1)) begin
                        state_d = DONE;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_comb begin
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
        a_d     = (state_d == SHIFT) && word_d[ch_d];
        sel_d   = (state_d == SHIFT) ? ch_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            ch_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ch_q    <= ch_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            sel_q   <= sel_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign a     = a_q;
    assign s0    = sel_q[2];
    assign s1    = sel_q[1];
    assign s2    = sel_q[0];

endmodule

// File: tb/tb_demux_serializer.sv
// Directed bench for demux_serializer with HOLD_CYCLES=1 and HOLD_CYCLES=3 instances.
module tb_demux_serializer;

    logic       clk = 1'b0;
    logic       rst1_n, rst3_n;
    logic [7:0] data1, data3;
    logic       load1, load3;
    logic       ready1, busy1, done1, a1, s0_1, s1_1, s2_1;
    logic       ready3, busy3, done3, a3, s0_3, s1_3, s2_3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_serializer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .data_in(data1), .load(load1),
        .ready(ready1), .busy(busy1), .done(done1),
        .a(a1), .s0(s0_1), .s1(s1_1), .s2(s2_1)
    );

    demux_serializer #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .data_in(data3), .load(load3),
        .ready(ready3), .busy(busy3), .done(done3),
        .a(a3), .s0(s0_3), .s1(s1_3), .s2(s2_3)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_a;   // bit k = expected a while channel k is presented
        int         hold;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // {ready,busy,done,a,sel[2:0]} of the selected instance
    function automatic int outs(input bit use3);
        if (use3) return int'({ready3, busy3, done3, a3, s0_3, s1_3, s2_3});
        return int'({ready1, busy1, done1, a1, s0_1, s1_1, s2_1});
    endfunction

    task automatic set_in(input bit use3, input logic ld, input logic [7:0] d);
        if (use3) begin load3 = ld; data3 = d; end
        else      begin load1 = ld; data1 = d; end
    endtask

    // Runs one word; optional ignored-load injection and reset at channel rst_ch.
    task automatic run_word(input bit use3, input logic [7:0] d, input logic [7:0] exp_a,
                            input int hold, input bit inject, input int rst_ch);
        int n;
        n = 0;
        while (((outs(use3) >> 6) & 1) == 0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("ready_timeout", 0, 1);
        set_in(use3, 1'b1, d);
        tick();
        last_accept = cyc;
        set_in(use3, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < hold; j++) begin
                if (k == rst_ch && j == 0) begin
                    if (use3) rst3_n = 1'b0; else rst1_n = 1'b0;
                    tick();
                    if (use3) rst3_n = 1'b1; else rst1_n = 1'b1;
                    chk("after_reset", outs(use3), 7'b100_0000);
                    for (int m = 0; m < 12; m++) begin
                        tick();
                        chk("no_done_after_reset", outs(use3), 7'b100_0000);
                    end
                    return;
                end
                chk($sformatf("shift_ch%0d", k), outs(use3),
                    int'({1'b0, 1'b1, 1'b0, exp_a[k], 3'(k)}));
                set_in(use3, inject && k == 3 && j == 0, 8'hFF);
                tick();
                set_in(use3, 1'b0, 8'h00);
            end
        end
        chk("done_pulse", outs(use3), 7'b001_0000);
        if (inject) set_in(use3, 1'b1, 8'hFF);
        tick();
        set_in(use3, 1'b0, 8'h00);
        chk("ready_back", outs(use3), 7'b100_0000);
        chk("cycles_to_ready", cyc - last_accept, 8 * hold + 1);
        if (inject) begin
            tick();
            chk("no_second_run", outs(use3), 7'b100_0000);
        end
    endtask

    initial begin
        int first;
        vecs[0] = '{data: 8'hA5, exp_a: 8'b1010_0101, hold: 1};
        vecs[1] = '{data: 8'h81, exp_a: 8'b1000_0001, hold: 3};
        vecs[2] = '{data: 8'h3C, exp_a: 8'b0011_1100, hold: 1};
        vecs[3] = '{data: 8'h00, exp_a: 8'b0000_0000, hold: 3};
        vecs[4] = '{data: 8'h6E, exp_a: 8'b0110_1110, hold: 3};

        rst1_n = 1'b0; rst3_n = 1'b0;
        load1 = 1'b1; load3 = 1'b1;
        data1 = 8'hFF; data3 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_dut1", outs(1'b0), 7'b100_0000);
            chk("reset_dut3", outs(1'b1), 7'b100_0000);
        end
        load1 = 1'b0; load3 = 1'b0;
        rst1_n = 1'b1; rst3_n = 1'b1;
        tick();
        chk("idle_dut1", outs(1'b0), 7'b100_0000);

        for (int i = 0; i < 5; i++) begin
            run_word(vecs[i].hold == 3, vecs[i].data, vecs[i].exp_a, vecs[i].hold, 1'b0, -1);
        end

        // Loads during SHIFT and DONE must not disturb a 3C word.
        run_word(1'b0, 8'h3C, 8'b0011_1100, 1, 1'b1, -1);

        // Reset at channel 4, then a fresh word runs normally.
        run_word(1'b0, 8'hFF, 8'hFF, 1, 1'b0, 4);
        run_word(1'b0, 8'h01, 8'b0000_0001, 1, 1'b0, -1);
        run_word(1'b1, 8'hFF, 8'hFF, 3, 1'b0, 4);
        run_word(1'b1, 8'h01, 8'b0000_0001, 3, 1'b0, -1);

        // Back-to-back: next acceptance on the first ready cycle.
        run_word(1'b0, 8'hC3, 8'b1100_0011, 1, 1'b0, -1);
        first = last_accept;
        run_word(1'b0, 8'h5A, 8'b0101_1010, 1, 1'b0, -1);
        chk("b2b_period_h1", last_accept - first, 10);
        run_word(1'b1, 8'h96, 8'b1001_0110, 3, 1'b0, -1);
        first = last_accept;
        run_word(1'b1, 8'h69, 8'b0110_1001, 3, 1'b0, -1);
        chk("b2b_period_h3", last_accept - first, 26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Exclusivity of handshake flags on both instances.
    always @(negedge clk) begin
        if ((ready1 && busy1) || (done1 && (ready1 || busy1)) ||
            (ready3 && busy3) || (done3 && (ready3 || busy3))) begin
            errors++;
            $display("FAIL flag_exclusive: got r1b1d1=%b%b%b r3b3d3=%b%b%b required one-hot",
                     ready1, busy1, done1, ready3, busy3, done3);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/demux_serializer.md
# demux_serializer

Upstream driver for the 1-to-8 demultiplexer stage. It accepts an 8-bit word through a load/ready handshake and presents it one bit at a time on the demux data line `a`, stepping the select lines `s0`, `s1`, `s2` so that bit *k* of the word appears on demux output *yk*. Each channel is held for a programmable number of cycles, and the block signals completion so that the downstream capture logic knows all eight outputs have been visited.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: cycles each channel is presented. Legal range is 1..255.

Ports:
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low; sampled on the `clk` rising edge.
- `data_in`  in  8: word to distribute; bit *k* is destined for demux output *yk*.
- `load`  in  1: request to start; accepted only on an edge where `ready`=1.
- `ready`  out  1: high only in IDLE.
- `busy`  out  1: high in SHIFT.
- `done`  out  1: one-cycle pulse in DONE.
- `a`  out  1: demux data line.
- `s0`  out  1: demux select, MSB of the channel index.
- `s1`  out  1: demux select, middle bit of the channel index.
- `s2`  out  1: demux select, LSB of the channel index.

## Operation
- The channel index `ch[2:0]` maps as `{s0,s1,s2}` = `ch`. Examples: `ch`=1 gives `s2`=1; `ch`=4 gives `s0`=1.
- The word is captured into an internal 8-bit register `word_q` on the accepting edge. Later changes to `data_in` have no effect.
- **States:**
  - **IDLE:** `ready`=1, `a`=0, selects=000.
    - `load`=1 captures the word, sets `ch`=0 and the hold counter to 0, and moves to SHIFT.
  - **SHIFT:** `busy`=1, `a`=`word_q[ch]`, selects=`ch`.
    - The hold counter increments every cycle.
    - When it reaches `HOLD_CYCLES`-1, it clears and `ch` increments.
    - When `ch`=7 and the counter reaches `HOLD_CYCLES`-1, the block moves to DONE.
  - **DONE:** `done`=1, `a`=0, selects=000, `ready`=0. Unconditionally returns to IDLE next edge.
- `a` is forced to 0 outside SHIFT, so every demux output is 0 whenever the block is not shifting.
- `load` is ignored in SHIFT and DONE. It is not queued.
- `rst_n`=0 on any edge, including mid-SHIFT, forces IDLE and clears `ch`, the hold counter and `word_q`. The partial word is discarded and `done` does not pulse.
- `rst_n`=0 together with `load`=1: reset wins.
- The hold counter is 8 bits wide. `ch` wraps from 7 to 0 only through DONE/IDLE, never directly.

## Timing
- **Reset values:** `ready`=1, `busy`=0, `done`=0, `a`=0, `s0`=0, `s1`=0, `s2`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Let edge E be the edge on which `load` is accepted. Then:
  - Channel 0 is presented in the cycle after E.
  - Channel *k* is presented for cycles E+1+*k*·`HOLD_CYCLES` through E+(*k*+1)·`HOLD_CYCLES`.
  - `done` is high in cycle E+8·`HOLD_CYCLES`+1.
  - `ready` returns high in cycle E+8·`HOLD_CYCLES`+2.
- The earliest next acceptance is that cycle. The minimum word period is 8·`HOLD_CYCLES`+2 cycles.
- `busy` and `ready` are never high together. `done` never coincides with either.

## Structure
- **Package `demux_serializer_pkg`:**
  - state enum `{IDLE, SHIFT, DONE}`
  - `CHANNELS`=8
  - `SEL_W`=3
  - `HOLD_W`=8
- **Sub-module `hold_timer`:** an 8-bit counter with synchronous clear/enable and a terminal-count output at `HOLD_CYCLES`-1. The FSM instantiates it once.
- The select bits are driven directly from `ch`. Output decode lives in the top level.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 edges with `load`=1 → outputs stay at reset values; `ready`=1 throughout.
- **Basic word, `HOLD_CYCLES`=1:** `data_in`=8'hA5, `load` at edge E → `a` sequence over E+1..E+8 is 1,0,1,0,0,1,0,1 with `{s0,s1,s2}`=0..7; `done`=1 at E+9; `ready`=1 at E+10. A connected demux shows `y0`, `y2`, `y5`, `y7` pulsing once each.
- **Hold stretch, `HOLD_CYCLES`=3:** `data_in`=8'h81 → `a`=1 for 3 cycles with selects=000, then 0 for 18 cycles, then `a`=1 for 3 cycles with selects=111; `done` at E+25.
- **Ignored loads:** pulse `load` with `data_in`=8'hFF during SHIFT and during DONE → the original 8'h3C pattern completes unchanged; no second run starts.
- **Reset mid-operation:** 8'hFF, assert `rst_n`=0 at `ch`=4 → next cycle `a`=0, selects=000, `ready`=1, no `done` pulse; a new `load` of 8'h01 runs normally.
- **Back-to-back:** reassert `load` at the first cycle `ready`=1 → the second word starts exactly 8·`HOLD_CYCLES`+2 cycles after the first acceptance.
